// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned FLAGS_W = 64;
    localparam int unsigned SIZE_W  = 2;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Byte-lane mask covering the low bytes selected by an access size.
    function automatic logic [DATA_W-1:0] size_mask(input mem_size_t size);
        logic [DATA_W-1:0] mask;
        case (size)
            MEM_B:   mask = 64'h0000_0000_0000_00FF;
            MEM_H:   mask = 64'h0000_0000_0000_FFFF;
            MEM_W:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: takes one executed micro-op per idle cycle, performs at
// most one data-cache load/store, and hands the completed micro-op to writeback.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned REG_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exe_mem,
    input  logic [127:0]        result,
    input  logic [63:0]         rflags,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic [REG_W-1:0]    dst_reg,
    input  logic                dst_we,
    output logic                mem_blocked,
    output logic                dreq_valid,
    input  logic                dreq_ready,
    output logic                dreq_we,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [1:0]          dreq_size,
    output logic [63:0]         dreq_wdata,
    input  logic                dresp_valid,
    input  logic [63:0]         dresp_data,
    output logic                wb_valid,
    output logic [63:0]         wb_data,
    output logic [63:0]         wb_rflags,
    output logic [REG_W-1:0]    wb_reg,
    output logic                wb_we
);

    mem_state_t          state_q,       state_d;
    logic                mem_blocked_q, mem_blocked_d;
    logic                dreq_valid_q,  dreq_valid_d;
    logic                dreq_we_q,     dreq_we_d;
    logic [ADDR_W-1:0]   dreq_addr_q,   dreq_addr_d;
    mem_size_t           dreq_size_q,   dreq_size_d;
    logic [DATA_W-1:0]   dreq_wdata_q,  dreq_wdata_d;
    logic [DATA_W-1:0]   data_q,        data_d;
    logic                dst_we_q,      dst_we_d;
    logic                wb_valid_q,    wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q,     wb_data_d;
    logic [FLAGS_W-1:0]  wb_rflags_q,   wb_rflags_d;
    logic [REG_W-1:0]    wb_reg_q,      wb_reg_d;
    logic                wb_we_q,       wb_we_d;

    mem_size_t           in_size;
    logic                unused_result_hi;

    assign in_size          = mem_size_t'(mem_size);
    assign unused_result_hi = ^result[127:64];

    // Next-state and capture logic.
    always_comb begin
        state_d       = state_q;
        mem_blocked_d = mem_blocked_q;
        dreq_valid_d  = dreq_valid_q;
        dreq_we_d     = dreq_we_q;
        dreq_addr_d   = dreq_addr_q;
        dreq_size_d   = dreq_size_q;
        dreq_wdata_d  = dreq_wdata_q;
        data_d        = data_q;
        dst_we_d      = dst_we_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rflags_d   = wb_rflags_q;
        wb_reg_d      = wb_reg_q;
        wb_we_d       = wb_we_q;

        case (state_q)
            IDLE: begin
                if (exe_mem) begin
                    data_d      = result[63:0];
                    dst_we_d    = dst_we;
                    wb_rflags_d = rflags;
                    wb_reg_d    = dst_reg;
                    if (mem_rd || mem_wr) begin
                        state_d       = REQ;
                        mem_blocked_d = 1'b1;
                        dreq_valid_d  = 1'b1;
                        // A micro-op flagged as both load and store is a load.
                        dreq_we_d     = mem_wr & ~mem_rd;
                        dreq_addr_d   = mem_addr;
                        dreq_size_d   = in_size;
                        dreq_wdata_d  = result[63:0] & size_mask(in_size);
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = result[63:0];
                        wb_we_d    = dst_we;
                    end
                end
            end
            REQ: begin
                if (dreq_valid_q && dreq_ready) begin
                    state_d      = WAIT;
                    dreq_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (dresp_valid) begin
                    state_d       = IDLE;
                    mem_blocked_d = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = dreq_we_q ? data_q : (dresp_data & size_mask(dreq_size_q));
                    wb_we_d       = dreq_we_q ? 1'b0 : dst_we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_blocked_q <= 1'b0;
            dreq_valid_q  <= 1'b0;
            dreq_we_q     <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= MEM_B;
            dreq_wdata_q  <= '0;
            data_q        <= '0;
            dst_we_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rflags_q   <= '0;
            wb_reg_q      <= '0;
            wb_we_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_blocked_q <= mem_blocked_d;
            dreq_valid_q  <= dreq_valid_d;
            dreq_we_q     <= dreq_we_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_size_q   <= dreq_size_d;
            dreq_wdata_q  <= dreq_wdata_d;
            data_q        <= data_d;
            dst_we_q      <= dst_we_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rflags_q   <= wb_rflags_d;
            wb_reg_q      <= wb_reg_d;
            wb_we_q       <= wb_we_d;
        end
    end

    assign mem_blocked = mem_blocked_q;
    assign dreq_valid  = dreq_valid_q;
    assign dreq_we     = dreq_we_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = 2'(dreq_size_q);
    assign dreq_wdata  = dreq_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rflags   = wb_rflags_q;
    assign wb_reg      = wb_reg_q;
    assign wb_we       = wb_we_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, store with held ALU op,
// and reset while a response is outstanding.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         exe_mem;
    logic [127:0] result;
    logic [63:0]  rflags;
    logic [63:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [1:0]   mem_size;
    logic [3:0]   dst_reg;
    logic         dst_we;
    logic         mem_blocked;
    logic         dreq_valid;
    logic         dreq_ready;
    logic         dreq_we;
    logic [63:0]  dreq_addr;
    logic [1:0]   dreq_size;
    logic [63:0]  dreq_wdata;
    logic         dresp_valid;
    logic [63:0]  dresp_data;
    logic         wb_valid;
    logic [63:0]  wb_data;
    logic [63:0]  wb_rflags;
    logic [3:0]   wb_reg;
    logic         wb_we;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.ADDR_W(64), .REG_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .exe_mem     (exe_mem),
        .result      (result),
        .rflags      (rflags),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .dst_reg     (dst_reg),
        .dst_we      (dst_we),
        .mem_blocked (mem_blocked),
        .dreq_valid  (dreq_valid),
        .dreq_ready  (dreq_ready),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_size   (dreq_size),
        .dreq_wdata  (dreq_wdata),
        .dresp_valid (dresp_valid),
        .dresp_data  (dresp_data),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rflags   (wb_rflags),
        .wb_reg      (wb_reg),
        .wb_we       (wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        exe_mem  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        exe_mem     = 1'b0;
        result      = '0;
        rflags      = '0;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_size    = 2'd0;
        dst_reg     = 4'd0;
        dst_we      = 1'b0;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        dresp_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_wb_valid",    64'(wb_valid),    64'd0);
        chk("rst_mem_blocked", 64'(mem_blocked), 64'd0);
        chk("rst_dreq_valid",  64'(dreq_valid),  64'd0);
        chk("rst_wb_data",     wb_data,          64'd0);
        reset = 1'b0;
        tick();

        // Pass-through
        exe_mem = 1'b1; result = 128'h1234; rflags = 64'h55; dst_reg = 4'd3; dst_we = 1'b1;
        tick();
        idle_inputs();
        chk("pt_wb_valid",    64'(wb_valid),    64'd1);
        chk("pt_wb_data",     wb_data,          64'h1234);
        chk("pt_wb_rflags",   wb_rflags,        64'h55);
        chk("pt_wb_reg",      64'(wb_reg),      64'd3);
        chk("pt_wb_we",       64'(wb_we),       64'd1);
        chk("pt_mem_blocked", 64'(mem_blocked), 64'd0);
        tick();
        chk("pt_wb_pulse",    64'(wb_valid),    64'd0);

        // Back-to-back pass-through, upper result bits are ignored
        exe_mem = 1'b1; result = {64'hFFFF_0000_FFFF_0000, 64'hA1}; dst_reg = 4'd4; dst_we = 1'b0;
        tick();
        chk("b2b0_wb_valid", 64'(wb_valid), 64'd1);
        chk("b2b0_wb_data",  wb_data,       64'hA1);
        chk("b2b0_wb_we",    64'(wb_we),    64'd0);
        result = 128'hB2; dst_reg = 4'd5; dst_we = 1'b1;
        tick();
        idle_inputs();
        chk("b2b1_wb_valid", 64'(wb_valid), 64'd1);
        chk("b2b1_wb_data",  wb_data,       64'hB2);
        chk("b2b1_wb_reg",   64'(wb_reg),   64'd5);
        tick();

        // Load 8B with a 2-cycle ready stall
        exe_mem = 1'b1; mem_rd = 1'b1; mem_addr = 64'h1000; mem_size = 2'd3;
        result = 128'h77; rflags = 64'h8; dst_reg = 4'd6; dst_we = 1'b1; dreq_ready = 1'b0;
        tick();
        idle_inputs();
        chk("ld8_dreq_valid0",  64'(dreq_valid),  64'd1);
        chk("ld8_dreq_addr0",   dreq_addr,        64'h1000);
        chk("ld8_dreq_we",      64'(dreq_we),     64'd0);
        chk("ld8_dreq_size",    64'(dreq_size),   64'd3);
        chk("ld8_mem_blocked",  64'(mem_blocked), 64'd1);
        chk("ld8_wb_valid0",    64'(wb_valid),    64'd0);
        dresp_valid = 1'b1; dresp_data = 64'h1111;
        tick();
        dresp_valid = 1'b0;
        chk("ld8_dreq_valid1",  64'(dreq_valid),  64'd1);
        chk("ld8_dreq_addr1",   dreq_addr,        64'h1000);
        chk("ld8_req_resp_ign", 64'(wb_valid),    64'd0);
        dreq_ready = 1'b1;
        tick();
        dreq_ready = 1'b0;
        chk("ld8_hs_drop",      64'(dreq_valid),  64'd0);
        chk("ld8_hs_blocked",   64'(mem_blocked), 64'd1);
        tick();
        chk("ld8_wait_wb",      64'(wb_valid),    64'd0);
        dresp_valid = 1'b1; dresp_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        dresp_valid = 1'b0;
        chk("ld8_wb_valid",     64'(wb_valid),    64'd1);
        chk("ld8_wb_data",      wb_data,          64'hDEADBEEF_CAFEF00D);
        chk("ld8_wb_we",        64'(wb_we),       64'd1);
        chk("ld8_wb_reg",       64'(wb_reg),      64'd6);
        chk("ld8_wb_rflags",    wb_rflags,        64'h8);
        chk("ld8_unblocked",    64'(mem_blocked), 64'd0);
        tick();
        chk("ld8_wb_pulse",     64'(wb_valid),    64'd0);

        // Load 1B, with rd and wr both set (must behave as a load)
        exe_mem = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 64'h2001; mem_size = 2'd0;
        result = 128'h5555; dst_reg = 4'd1; dst_we = 1'b1; dreq_ready = 1'b1;
        tick();
        idle_inputs();
        chk("ld1_dreq_we",   64'(dreq_we),   64'd0);
        chk("ld1_dreq_size", 64'(dreq_size), 64'd0);
        chk("ld1_dreq_addr", dreq_addr,      64'h2001);
        tick();
        dreq_ready = 1'b0;
        dresp_valid = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FF80;
        tick();
        dresp_valid = 1'b0;
        chk("ld1_wb_valid", 64'(wb_valid), 64'd1);
        chk("ld1_wb_data",  wb_data,       64'h80);
        chk("ld1_wb_we",    64'(wb_we),    64'd1);
        tick();

        // Store 4B followed by an ADD held on the ALU outputs
        exe_mem = 1'b1; mem_wr = 1'b1; mem_addr = 64'h3000; mem_size = 2'd2;
        result = 128'hAAAA_BBBB_CCCC_DDDD; rflags = 64'h40; dst_reg = 4'd7; dst_we = 1'b1;
        dreq_ready = 1'b0;
        tick();
        mem_wr = 1'b0; mem_size = 2'd3; result = 128'h99; rflags = 64'h2; dst_reg = 4'd2; dst_we = 1'b1;
        chk("st_dreq_we",     64'(dreq_we),     64'd1);
        chk("st_dreq_wdata",  dreq_wdata,       64'hCCCC_DDDD);
        chk("st_dreq_size",   64'(dreq_size),   64'd2);
        chk("st_mem_blocked", 64'(mem_blocked), 64'd1);
        chk("st_no_add_wb0",  64'(wb_valid),    64'd0);
        dreq_ready = 1'b1;
        tick();
        dreq_ready = 1'b0;
        chk("st_no_add_wb1",  64'(wb_valid),    64'd0);
        tick();
        chk("st_no_add_wb2",  64'(wb_valid),    64'd0);
        chk("st_wait_blocked", 64'(mem_blocked), 64'd1);
        dresp_valid = 1'b1; dresp_data = 64'h1111_2222;
        tick();
        dresp_valid = 1'b0;
        chk("st_wb_valid",    64'(wb_valid),    64'd1);
        chk("st_wb_we",       64'(wb_we),       64'd0);
        chk("st_wb_data",     wb_data,          64'hAAAA_BBBB_CCCC_DDDD);
        chk("st_wb_reg",      64'(wb_reg),      64'd7);
        chk("st_wb_rflags",   wb_rflags,        64'h40);
        chk("st_unblocked",   64'(mem_blocked), 64'd0);
        tick();
        idle_inputs();
        chk("add_wb_valid",   64'(wb_valid),    64'd1);
        chk("add_wb_data",    wb_data,          64'h99);
        chk("add_wb_reg",     64'(wb_reg),      64'd2);
        chk("add_wb_we",      64'(wb_we),       64'd1);
        chk("add_blocked",    64'(mem_blocked), 64'd0);
        tick();
        chk("add_wb_once",    64'(wb_valid),    64'd0);

        // Reset while in WAIT, then a stray response
        exe_mem = 1'b1; mem_rd = 1'b1; mem_addr = 64'h4000; mem_size = 2'd3;
        rflags = 64'hF0; dst_reg = 4'd9; dst_we = 1'b1; dreq_ready = 1'b1;
        tick();
        idle_inputs();
        tick();
        dreq_ready = 1'b0;
        chk("rw_in_wait", 64'(mem_blocked), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_dreq_valid",  64'(dreq_valid),  64'd0);
        chk("rw_mem_blocked", 64'(mem_blocked), 64'd0);
        chk("rw_dreq_addr",   dreq_addr,        64'd0);
        chk("rw_wb_rflags",   wb_rflags,        64'd0);
        chk("rw_wb_reg",      64'(wb_reg),      64'd0);
        tick();
        reset = 1'b0;
        dresp_valid = 1'b1; dresp_data = 64'hBAD;
        tick();
        dresp_valid = 1'b0;
        chk("rw_stray_wb",      64'(wb_valid),    64'd0);
        chk("rw_stray_blocked", 64'(mem_blocked), 64'd0);
        tick();
        chk("rw_stray_wb2",     64'(wb_valid),    64'd0);
        exe_mem = 1'b1; result = 128'h4242; dst_reg = 4'd8; dst_we = 1'b1;
        tick();
        idle_inputs();
        chk("rw_idle_pt_valid", 64'(wb_valid),    64'd1);
        chk("rw_idle_pt_data",  wb_data,          64'h4242);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
